// File: rtl/motor_ramp_sequencer.sv
// Slew-limited speed/direction sequencer for motor_controller; reversals pass through stop plus dead time.
// Optional build macro MOTOR_ESTOP_EN enables the estop input and the STOPPED state.
module motor_ramp_sequencer #(
    parameter logic [15:0] RAMP_DIV    = 16'd1000,
    parameter logic [6:0]  STEP        = 7'd10,
    parameter logic [3:0]  DEAD_TICKS  = 4'd4,
    parameter logic [6:0]  PERIOD_SLOW = 7'd127,
    parameter logic [6:0]  PERIOD_MIN  = 7'd20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_m1_sign,
    input  logic [6:0] i_cmd_m1_period,
    input  logic       i_cmd_m2_sign,
    input  logic [6:0] i_cmd_m2_period,
    input  logic       i_estop,
    output logic       o_motor1_sign,
    output logic [6:0] o_motor1_period,
    output logic       o_motor2_sign,
    output logic [6:0] o_motor2_period,
    output logic       o_settled
);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RAMP,
        ST_BRAKE,
`ifdef MOTOR_ESTOP_EN
        ST_DEAD,
        ST_STOPPED
`else
        ST_DEAD
`endif
    } state_t;

    logic [15:0] r_presc;
    logic        r_cmd_ready;
    logic        r_settled;
    logic        w_tick;
    logic        w_accept;
    logic        w_estop;
    logic        w_out_sign   [2];
    logic [6:0]  w_out_period [2];
    logic        w_dead       [2];
    logic        w_calm       [2];

`ifdef MOTOR_ESTOP_EN
    assign w_estop = i_estop;
`else
    logic w_unused_estop;
    assign w_unused_estop = i_estop;
    assign w_estop        = 1'b0;
`endif

    assign w_tick   = (r_presc == RAMP_DIV - 16'd1);
    assign w_accept = i_cmd_valid && r_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= 16'd0;
        end else if (w_tick) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_motor
        state_t     r_state;
        state_t     w_state_nxt;
        logic       r_sign;
        logic       w_sign_nxt;
        logic [6:0] r_period;
        logic [6:0] w_period_nxt;
        logic [3:0] r_dead_cnt;
        logic [3:0] w_dead_nxt;
        logic       r_tgt_sign;
        logic [6:0] r_tgt_period;
        logic       w_cmd_sign;
        logic [6:0] w_cmd_raw;
        logic [6:0] w_cmd_period;
        logic       w_tgt_chg;
        logic       w_tgt_sign_nxt;
        logic [6:0] w_tgt_period_nxt;
        logic [7:0] w_up;
        logic [7:0] w_gap;

        assign w_cmd_sign   = (g == 0) ? i_cmd_m1_sign : i_cmd_m2_sign;
        assign w_cmd_raw    = (g == 0) ? i_cmd_m1_period : i_cmd_m2_period;
        assign w_cmd_period = (w_cmd_raw < PERIOD_MIN) ? PERIOD_MIN : w_cmd_raw;

        assign w_tgt_chg        = w_accept && ((w_cmd_sign != r_tgt_sign) || (w_cmd_period != r_tgt_period));
        assign w_tgt_sign_nxt   = w_accept ? w_cmd_sign : r_tgt_sign;
        assign w_tgt_period_nxt = w_accept ? w_cmd_period : r_tgt_period;

        // 8-bit intermediates so neither the brake climb nor the gap can wrap
        assign w_up  = {1'b0, r_period} + {1'b0, STEP};
        assign w_gap = (r_period >= r_tgt_period) ? {1'b0, r_period - r_tgt_period}
                                                  : {1'b0, r_tgt_period - r_period};

        always_comb begin
            w_state_nxt  = r_state;
            w_sign_nxt   = r_sign;
            w_period_nxt = r_period;
            w_dead_nxt   = r_dead_cnt;
`ifdef MOTOR_ESTOP_EN
            if (w_estop) begin
                w_state_nxt  = ST_STOPPED;
                w_period_nxt = PERIOD_SLOW;
            end else if (r_state == ST_STOPPED) begin
                if (w_accept) begin
                    if (w_cmd_sign == r_sign) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = ST_DEAD;
                        w_dead_nxt  = 4'd0;
                    end
                end
            end else
`endif
            if (w_tick) begin
                case (r_state)
                    ST_HOLD: begin
                        if (r_tgt_sign != r_sign) begin
                            w_state_nxt = ST_BRAKE;
                        end else if (r_tgt_period != r_period) begin
                            w_state_nxt = ST_RAMP;
                        end
                    end
                    ST_RAMP: begin
                        if (r_tgt_sign != r_sign) begin
                            w_state_nxt = ST_BRAKE;
                        end else if (w_gap <= {1'b0, STEP}) begin
                            w_period_nxt = r_tgt_period;
                            w_state_nxt  = ST_HOLD;
                        end else if (r_period > r_tgt_period) begin
                            w_period_nxt = r_period - STEP;
                        end else begin
                            w_period_nxt = r_period + STEP;
                        end
                    end
                    ST_BRAKE: begin
                        if (r_tgt_sign == r_sign) begin
                            w_state_nxt = ST_RAMP;
                        end else if (w_up >= {1'b0, PERIOD_SLOW}) begin
                            w_period_nxt = PERIOD_SLOW;
                            w_state_nxt  = ST_DEAD;
                            w_dead_nxt   = 4'd0;
                        end else begin
                            w_period_nxt = w_up[6:0];
                        end
                    end
                    ST_DEAD: begin
                        w_period_nxt = PERIOD_SLOW;
                        if (r_dead_cnt == DEAD_TICKS - 4'd1) begin
                            w_sign_nxt  = r_tgt_sign;
                            w_state_nxt = ST_RAMP;
                        end else begin
                            w_dead_nxt = r_dead_cnt + 4'd1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_HOLD;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_state      <= ST_HOLD;
                r_sign       <= 1'b0;
                r_period     <= PERIOD_SLOW;
                r_dead_cnt   <= 4'd0;
                r_tgt_sign   <= 1'b0;
                r_tgt_period <= PERIOD_SLOW;
            end else begin
                r_state      <= w_state_nxt;
                r_sign       <= w_sign_nxt;
                r_period     <= w_period_nxt;
                r_dead_cnt   <= w_dead_nxt;
                r_tgt_sign   <= w_tgt_sign_nxt;
                r_tgt_period <= w_tgt_period_nxt;
            end
        end

        assign w_out_sign[g]   = r_sign;
        assign w_out_period[g] = r_period;
        assign w_dead[g]       = (r_state == ST_DEAD);
        assign w_calm[g]       = !w_tgt_chg && (w_state_nxt == ST_HOLD) &&
                                 (w_sign_nxt == w_tgt_sign_nxt) && (w_period_nxt == w_tgt_period_nxt);
    end

    // Ready lags the state by one cycle, so a command can still land on the cycle DEAD is entered
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd_ready <= 1'b0;
            r_settled   <= 1'b1;
        end else begin
            r_cmd_ready <= !w_estop && !w_dead[0] && !w_dead[1];
            r_settled   <= w_calm[0] && w_calm[1];
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_settled       = r_settled;
    assign o_motor1_sign   = w_out_sign[0];
    assign o_motor1_period = w_out_period[0];
    assign o_motor2_sign   = w_out_sign[1];
    assign o_motor2_period = w_out_period[1];

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Self-checking bench for motor_ramp_sequencer: directed ramp/reversal/clamp/reset scenarios plus
// randomized commands against a behavioural model (estop scenario when MOTOR_ESTOP_EN is defined).
module tb_motor_ramp_sequencer;

    localparam int RDIV = 4;
    localparam int STEP = 10;
    localparam int DEAD = 2;
    localparam int SLOW = 127;
    localparam int PMIN = 20;

    localparam int IDLE  = 0;
    localparam int MOVE  = 1;
    localparam int REV   = 2;
    localparam int WAITD = 3;
    localparam int STOP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmdValid = 1'b0;
    logic       cmdM1Sign = 1'b0;
    logic [6:0] cmdM1Period = 7'd0;
    logic       cmdM2Sign = 1'b0;
    logic [6:0] cmdM2Period = 7'd0;
    logic       estop = 1'b0;
    logic       cmdReady;
    logic       motor1Sign;
    logic [6:0] motor1Period;
    logic       motor2Sign;
    logic [6:0] motor2Period;
    logic       settled;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;

    // Behavioural model state
    int mPresc = 0;
    bit mReady = 0;
    bit mSettled = 1;
    int tgtS[2];
    int tgtP[2];
    int outS[2];
    int outP[2];
    int phase[2];
    int dcnt[2];

    always #5 clk = ~clk;

    motor_ramp_sequencer #(
        .RAMP_DIV   (16'd4),
        .STEP       (7'd10),
        .DEAD_TICKS (4'd2),
        .PERIOD_SLOW(7'd127),
        .PERIOD_MIN (7'd20)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cmd_valid    (cmdValid),
        .o_cmd_ready    (cmdReady),
        .i_cmd_m1_sign  (cmdM1Sign),
        .i_cmd_m1_period(cmdM1Period),
        .i_cmd_m2_sign  (cmdM2Sign),
        .i_cmd_m2_period(cmdM2Period),
        .i_estop        (estop),
        .o_motor1_sign  (motor1Sign),
        .o_motor1_period(motor1Period),
        .o_motor2_sign  (motor2Sign),
        .o_motor2_period(motor2Period),
        .o_settled      (settled)
    );

    // One clock edge of the reference: speed ramps toward target, reversals go via slow + dead time
    function automatic void modelStep();
        bit acc;
        bit tick;
        bit estopAct;
        bit chg;
        bit anyWait;
        int nS[2];
        int nP[2];
        int d;
        acc  = cmdValid && mReady;
        tick = (mPresc == RDIV - 1);
`ifdef MOTOR_ESTOP_EN
        estopAct = estop;
`else
        estopAct = 1'b0;
`endif
        if (reset) begin
            mPresc   = 0;
            mReady   = 0;
            mSettled = 1;
            for (int m = 0; m < 2; m++) begin
                outS[m] = 0; outP[m] = SLOW; tgtS[m] = 0; tgtP[m] = SLOW; phase[m] = IDLE; dcnt[m] = 0;
            end
            return;
        end
        anyWait = (phase[0] == WAITD) || (phase[1] == WAITD);
        mPresc  = tick ? 0 : mPresc + 1;
        nS[0] = int'(cmdM1Sign);
        nS[1] = int'(cmdM2Sign);
        nP[0] = (int'(cmdM1Period) < PMIN) ? PMIN : int'(cmdM1Period);
        nP[1] = (int'(cmdM2Period) < PMIN) ? PMIN : int'(cmdM2Period);
        chg = acc && (nS[0] != tgtS[0] || nP[0] != tgtP[0] || nS[1] != tgtS[1] || nP[1] != tgtP[1]);
        for (int m = 0; m < 2; m++) begin
            if (estopAct) begin
                outP[m]  = SLOW;
                phase[m] = STOP;
            end else if (phase[m] == STOP) begin
                if (acc) begin
                    if (nS[m] == outS[m]) phase[m] = MOVE;
                    else begin phase[m] = WAITD; dcnt[m] = 0; end
                end
            end else if (tick) begin
                case (phase[m])
                    IDLE: begin
                        if (tgtS[m] != outS[m]) phase[m] = REV;
                        else if (tgtP[m] != outP[m]) phase[m] = MOVE;
                    end
                    MOVE: begin
                        if (tgtS[m] != outS[m]) phase[m] = REV;
                        else begin
                            d = tgtP[m] - outP[m];
                            if (d <= STEP && d >= -STEP) begin outP[m] = tgtP[m]; phase[m] = IDLE; end
                            else outP[m] = outP[m] + ((d > 0) ? STEP : -STEP);
                        end
                    end
                    REV: begin
                        if (tgtS[m] == outS[m]) phase[m] = MOVE;
                        else begin
                            outP[m] = (outP[m] + STEP > SLOW) ? SLOW : outP[m] + STEP;
                            if (outP[m] == SLOW) begin phase[m] = WAITD; dcnt[m] = 0; end
                        end
                    end
                    WAITD: begin
                        if (dcnt[m] == DEAD - 1) begin outS[m] = tgtS[m]; phase[m] = MOVE; end
                        else dcnt[m] = dcnt[m] + 1;
                    end
                    default: ;
                endcase
            end
        end
        if (acc) begin
            for (int m = 0; m < 2; m++) begin tgtS[m] = nS[m]; tgtP[m] = nP[m]; end
        end
        mReady   = !estopAct && !anyWait;
        mSettled = !chg;
        for (int m = 0; m < 2; m++) begin
            if (phase[m] != IDLE || outS[m] != tgtS[m] || outP[m] != tgtP[m]) mSettled = 0;
        end
    endfunction

    task automatic advanceCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cycleCount++;
    endtask

    task automatic sendCmd(input logic s1, input logic [6:0] p1, input logic s2, input logic [6:0] p2);
        bit rdy;
        int budget;
        cmdM1Sign = s1; cmdM1Period = p1; cmdM2Sign = s2; cmdM2Period = p2;
        cmdValid = 1'b1;
        budget = 0;
        do begin
            rdy = cmdReady;
            advanceCycle();
            budget++;
        end while (!rdy && budget < 100);
        cmdValid = 1'b0;
        testsRun++;
        if (!rdy) begin
            testsFailed++;
            $display("[TB] FAIL cmd_accept_timeout: ready=%0b after %0d cycles, required 1", cmdReady, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmdValid = 1'b0; estop = 1'b0;
        advanceCycle();
        advanceCycle();
        testsRun++;
        if ({motor1Period, motor2Period} !== {7'd127, 7'd127}) begin
            testsFailed++;
            $display("[TB] FAIL reset_periods: got %0d/%0d required 127/127", motor1Period, motor2Period);
        end
        testsRun++;
        if ({motor1Sign, motor2Sign} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_signs: got %0b/%0b required 0/0", motor1Sign, motor2Sign);
        end
        testsRun++;
        if ({cmdReady, settled} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready_settled: got %0b/%0b required 0/1", cmdReady, settled);
        end
        reset = 1'b0;
        testsRun++;
        if (cmdReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ready_before_edge: got %0b required 0", cmdReady);
        end
        advanceCycle();
        testsRun++;
        if ({cmdReady, settled} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_reset: got ready=%0b settled=%0b required 1/1", cmdReady, settled);
        end
    endtask

    task automatic test_ramp();
        int seq[$];
        int when[$];
        int expSeq[4] = '{117, 107, 97, 87};
        int last;
        sendCmd(1'b0, 7'd87, 1'b0, 7'd127);
        testsRun++;
        if (settled !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ramp_settled_after_accept: got %0b required 0", settled);
        end
        last = int'(motor1Period);
        for (int i = 0; i < 80; i++) begin
            advanceCycle();
            if (int'(motor1Period) != last) begin seq.push_back(int'(motor1Period)); when.push_back(cycleCount); end
            last = int'(motor1Period);
            if (last == 87 && settled) break;
        end
        testsRun++;
        if (seq.size() != 4) begin
            testsFailed++;
            $display("[TB] FAIL ramp_steps: got %0d period changes required 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                testsRun++;
                if (seq[i] != expSeq[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL ramp_value[%0d]: got %0d required %0d", i, seq[i], expSeq[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                testsRun++;
                if (when[i] - when[i-1] != RDIV) begin
                    testsFailed++;
                    $display("[TB] FAIL ramp_spacing[%0d]: got %0d cycles required %0d", i, when[i] - when[i-1], RDIV);
                end
            end
        end
        testsRun++;
        if ({settled, motor1Sign, motor2Period} !== {1'b1, 1'b0, 7'd127}) begin
            testsFailed++;
            $display("[TB] FAIL ramp_final: got settled=%0b sign=%0b m2=%0d required 1/0/127", settled, motor1Sign, motor2Period);
        end
    endtask

    task automatic test_reversal();
        int seq[$];
        int expSeq[12] = '{97, 107, 117, 127, 117, 107, 97, 87, 77, 67, 57, 50};
        int last;
        int reach127 = -1;
        int flipAt = -1;
        int flipPeriod = -1;
        int readyLow = 0;
        logic prevSign;
        sendCmd(1'b1, 7'd50, 1'b0, 7'd127);
        last = int'(motor1Period);
        prevSign = motor1Sign;
        for (int i = 0; i < 200; i++) begin
            advanceCycle();
            if (int'(motor1Period) != last) begin
                seq.push_back(int'(motor1Period));
                if (motor1Period == 7'd127 && reach127 < 0) reach127 = cycleCount;
            end
            if (motor1Sign != prevSign && flipAt < 0) begin flipAt = cycleCount; flipPeriod = int'(motor1Period); end
            if (!cmdReady) readyLow++;
            last = int'(motor1Period);
            prevSign = motor1Sign;
            if (last == 50 && settled) break;
        end
        testsRun++;
        if (seq.size() != 12) begin
            testsFailed++;
            $display("[TB] FAIL reversal_steps: got %0d period changes required 12", seq.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                testsRun++;
                if (seq[i] != expSeq[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL reversal_value[%0d]: got %0d required %0d", i, seq[i], expSeq[i]);
                end
            end
        end
        testsRun++;
        if (flipAt - reach127 != DEAD * RDIV || flipPeriod != SLOW) begin
            testsFailed++;
            $display("[TB] FAIL reversal_dead_time: got %0d cycles at period %0d required %0d at %0d",
                     flipAt - reach127, flipPeriod, DEAD * RDIV, SLOW);
        end
        testsRun++;
        if (readyLow != DEAD * RDIV) begin
            testsFailed++;
            $display("[TB] FAIL reversal_ready_stall: got %0d low cycles required %0d", readyLow, DEAD * RDIV);
        end
        testsRun++;
        if ({motor1Sign, settled} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL reversal_final: got sign=%0b settled=%0b required 1/1", motor1Sign, settled);
        end
    endtask

    task automatic test_clamp();
        int minP = 127;
        sendCmd(1'b1, 7'd50, 1'b0, 7'd5);
        for (int i = 0; i < 100; i++) begin
            advanceCycle();
            if (int'(motor2Period) < minP) minP = int'(motor2Period);
            if (settled) break;
        end
        testsRun++;
        if (motor2Period !== 7'd20 || minP != PMIN) begin
            testsFailed++;
            $display("[TB] FAIL clamp: got final %0d min %0d required 20/20", motor2Period, minP);
        end
        testsRun++;
        if (settled !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clamp_settled: got %0b required 1", settled);
        end
    endtask

    task automatic test_reset_midramp();
        bit hit = 0;
        sendCmd(1'b1, 7'd90, 1'b0, 7'd20);
        for (int i = 0; i < 60; i++) begin
            advanceCycle();
            if (motor1Period == 7'd70) begin hit = 1; break; end
        end
        testsRun++;
        if (!hit) begin
            testsFailed++;
            $display("[TB] FAIL midramp_reach70: got period %0d required 70 within 60 cycles", motor1Period);
        end
        reset = 1'b1;
        advanceCycle();
        testsRun++;
        if ({motor1Sign, motor1Period, motor2Sign, motor2Period, settled, cmdReady} !==
            {1'b0, 7'd127, 1'b0, 7'd127, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL midramp_reset: got %0b/%0d %0b/%0d settled=%0b ready=%0b required 0/127 0/127 1 0",
                     motor1Sign, motor1Period, motor2Sign, motor2Period, settled, cmdReady);
        end
        reset = 1'b0;
        for (int i = 0; i < 2 * RDIV; i++) advanceCycle();
        testsRun++;
        if ({motor1Period, motor2Period, settled} !== {7'd127, 7'd127, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_idle: got %0d/%0d settled=%0b required 127/127 1", motor1Period, motor2Period, settled);
        end
    endtask

`ifdef MOTOR_ESTOP_EN
    task automatic test_estop();
        int seq[$];
        int expSeq[7] = '{117, 107, 97, 87, 77, 67, 60};
        int last;
        sendCmd(1'b0, 7'd60, 1'b0, 7'd127);
        for (int i = 0; i < 40; i++) begin
            advanceCycle();
            if (motor1Period <= 7'd107) break;
        end
        estop = 1'b1;
        advanceCycle();
        testsRun++;
        if ({motor1Period, motor2Period, cmdReady, settled} !== {7'd127, 7'd127, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL estop_apply: got %0d/%0d ready=%0b settled=%0b required 127/127 0 0",
                     motor1Period, motor2Period, cmdReady, settled);
        end
        for (int i = 0; i < 6; i++) advanceCycle();
        estop = 1'b0;
        for (int i = 0; i < 2 * RDIV; i++) advanceCycle();
        testsRun++;
        if ({motor1Period, cmdReady, settled} !== {7'd127, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL estop_stopped: got %0d ready=%0b settled=%0b required 127 1 0", motor1Period, cmdReady, settled);
        end
        sendCmd(1'b0, 7'd60, 1'b0, 7'd127);
        last = int'(motor1Period);
        for (int i = 0; i < 80; i++) begin
            advanceCycle();
            if (int'(motor1Period) != last) seq.push_back(int'(motor1Period));
            last = int'(motor1Period);
            if (last == 60 && settled) break;
        end
        testsRun++;
        if (seq.size() != 7) begin
            testsFailed++;
            $display("[TB] FAIL estop_resume_steps: got %0d changes required 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                testsRun++;
                if (seq[i] != expSeq[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL estop_resume[%0d]: got %0d required %0d", i, seq[i], expSeq[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [17:0] obs;
        logic [17:0] exp;
        for (int i = 0; i < 900; i++) begin
            cmdValid    = ($urandom_range(0, 29) == 0);
            cmdM1Sign   = 1'($urandom_range(0, 1));
            cmdM1Period = 7'($urandom_range(0, 127));
            cmdM2Sign   = 1'($urandom_range(0, 1));
            cmdM2Period = 7'($urandom_range(0, 127));
            estop       = ($urandom_range(0, 99) == 0);
            advanceCycle();
            obs = {motor1Sign, motor1Period, motor2Sign, motor2Period, cmdReady, settled};
            exp = {1'(outS[0]), 7'(outP[0]), 1'(outS[1]), 7'(outP[1]), mReady, mSettled};
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL random_cycle %0d: got s1=%0b p1=%0d s2=%0b p2=%0d rdy=%0b st=%0b required s1=%0b p1=%0d s2=%0b p2=%0d rdy=%0b st=%0b",
                         i, obs[17], obs[16:10], obs[9], obs[8:2], obs[1], obs[0],
                         exp[17], exp[16:10], exp[9], exp[8:2], exp[1], exp[0]);
            end
        end
        cmdValid = 1'b0;
        estop    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reversal();
        test_clamp();
        test_reset_midramp();
`ifdef MOTOR_ESTOP_EN
        test_estop();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cycleCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
